ibex_l2_register_file_mp: RTL and testbench
===========================================

Name: ibex_l2_register_file_mp

Overview:
- Parametrised successor to the single-port L2 flip-flop register file.
- Adds configurable depth and width, one write port, N registered read ports with write-to-read bypass, and an optional hard-wired zero word.
- Adds a sequential hardware clear engine.
- Sits beside the core as L2 scratch/state storage; targets FPGA and Verilator flows.

Parameters:
- DataWidth, 32, bits per word.
- NumWords, 28, number of words; must be at least 2.
- NumReadPorts, 2, independent read ports; 1 to 4.
- ZeroReg, 1, 1 = word 0 reads as zero and ignores writes; 0 = word 0 is normal storage.
- AddrWidth, $clog2(NumWords), derived localparam; not overridable.

Ports:
- clk_i  in  1  clock
- rst_ni  in  1  reset, asynchronous, active-low
- we_i  in  1  write enable
- waddr_i  in  AddrWidth  write address
- wdata_i  in  DataWidth  write data
- re_i  in  NumReadPorts  read request, one bit per port
- raddr_i  in  NumReadPorts*AddrWidth  read addresses, packed; port p is at slice [p*AddrWidth +: AddrWidth]
- rdata_o  out  NumReadPorts*DataWidth  registered read data, packed the same way
- rvalid_o  out  NumReadPorts  read data valid, one bit per port
- clear_i  in  1  start a sequential clear; single-cycle pulse
- busy_o  out  1  clear in progress
- parity_inj_i  in  1  flip the stored parity bit on this write; only meaningful with the optional feature
- parity_err_o  out  NumReadPorts  parity mismatch on the returned read

Behaviour:
- Reset (asynchronous, active-low):
  - all words, rdata_o, rvalid_o and parity_err_o go to 0;
  - FSM goes to IDLE, clear counter to 0, busy_o to 0.
  - Reset asserted mid-clear aborts the clear; storage is zeroed by the reset itself.
- FSM has two states, IDLE and CLEAR.
  - IDLE -> CLEAR when clear_i=1. The counter loads 0 and busy_o=1 from the next cycle.
  - In CLEAR, word[counter] is zeroed each cycle and the counter increments.
  - When the counter reaches NumWords-1, that word is zeroed and the FSM returns to IDLE. busy_o=1 for exactly NumWords cycles.
  - clear_i while in CLEAR is ignored.
- Writes:
  - In IDLE, when we_i=1, word[waddr_i] is written at the clock edge.
  - A write is dropped when waddr_i >= NumWords, when waddr_i=0 with ZeroReg=1, while busy_o=1, or in the cycle clear_i is accepted (clear wins).
- Reads:
  - Each port is independent. re_i[p] is sampled at the edge when busy_o=0.
  - Next cycle: rvalid_o[p]=1 and rdata_o[p] holds the word. Latency is 1 cycle.
  - rvalid_o[p] is high for one cycle per request; back-to-back requests give continuous valid.
  - With re_i[p]=0, rvalid_o[p]=0 and rdata_o[p] holds its last value.
  - Out-of-range address returns 0 with rvalid_o=1. Address 0 with ZeroReg=1 returns 0.
  - Requests while busy_o=1 are dropped (rvalid_o stays 0). A request in the cycle clear_i is accepted returns pre-clear data.
- Bypass:
  - If an accepted write and a read hit the same valid address in the same cycle, rdata_o returns wdata_i (write-first).
  - Multiple ports may read the same address in the same cycle.

Optional Feature:
- Macro: IBEX_L2_RF_PARITY_EN.
- Defined:
  - each word stores one extra even-parity bit, computed from wdata_i on write;
  - parity_inj_i=1 on a write stores the inverted parity bit;
  - a read (including a bypassed read) recomputes parity. parity_err_o[p] is asserted together with rvalid_o[p] when the computed and stored bits mismatch;
  - clear and reset store parity 0, which is consistent with zero data;
  - word 0 with ZeroReg=1 never flags an error.
- Undefined: no parity storage; parity_inj_i is ignored and parity_err_o is tied to 0.

Test Plan:
- Reset, then write 0xDEADBEEF to addr 5; read addr 5 on port 0 the next cycle -> rvalid_o[0]=1 one cycle later with rdata 0xDEADBEEF; rvalid_o[1]=0.
- ZeroReg=1: write 0x1234 to addr 0, then read addr 0 -> 0x0. Write to addr 28 with NumWords=28 -> dropped; reading addr 28 returns 0.
- Same cycle: write 0xA5A5A5A5 to addr 3 with both ports reading addr 3 -> both ports return 0xA5A5A5A5 after 1 cycle.
- Fill words 1..27 with their index, pulse clear_i -> busy_o high for exactly 28 cycles. Writes and reads during busy are dropped. Afterwards every word reads 0.
- Assert rst_ni low at clear counter=10 -> busy_o=0 immediately, FSM in IDLE, all reads return 0; a new clear_i is accepted normally.
- With IBEX_L2_RF_PARITY_EN: write 0x00000001 to addr 7 with parity_inj_i=1, then read -> parity_err_o=1 with rvalid_o. Rewrite without injection -> parity_err_o=0. Without the macro -> parity_err_o always 0.

Source files
------------

// File: rtl/ibex_l2_register_file_mp.sv
// Multi-port flip-flop register file: 1 write port, NumReadPorts registered read ports with write-first bypass, sequential clear engine.
// Read latency 1 cycle; writes/reads are dropped while busy_o. Define IBEX_L2_RF_PARITY_EN to add per-word even parity.
module ibex_l2_register_file_mp #(
  parameter int DataWidth    = 32,
  parameter int NumWords     = 28,
  parameter int NumReadPorts = 2,
  parameter int ZeroReg      = 1,
  localparam int AddrWidth   = $clog2(NumWords)
) (
  input  logic                              clk_i,
  input  logic                              rst_ni,
  input  logic                              we_i,
  input  logic [AddrWidth-1:0]              waddr_i,
  input  logic [DataWidth-1:0]              wdata_i,
  input  logic [NumReadPorts-1:0]           re_i,
  input  logic [NumReadPorts*AddrWidth-1:0] raddr_i,
  output logic [NumReadPorts*DataWidth-1:0] rdata_o,
  output logic [NumReadPorts-1:0]           rvalid_o,
  input  logic                              clear_i,
  output logic                              busy_o,
  input  logic                              parity_inj_i,
  output logic [NumReadPorts-1:0]           parity_err_o
);

  localparam logic [AddrWidth:0]   NumWordsA = (AddrWidth+1)'(NumWords);
  localparam logic [AddrWidth-1:0] LastIdx   = AddrWidth'(NumWords - 1);

  typedef enum logic {IDLE, CLEAR} state_e;

  state_e                            state_q, state_d;
  logic [AddrWidth-1:0]              cnt_q, cnt_d;
  logic [DataWidth-1:0]              mem_q [NumWords];
  logic [DataWidth-1:0]              mem_d [NumWords];
  logic [NumReadPorts*DataWidth-1:0] rdata_q, rdata_d;
  logic [NumReadPorts-1:0]           rvalid_q, rvalid_d;
  logic                              idle;
  logic                              wr_ok;

`ifdef IBEX_L2_RF_PARITY_EN
  logic                    par_q [NumWords];
  logic                    par_d [NumWords];
  logic [NumReadPorts-1:0] perr_q, perr_d;
  logic                    wpar;

  assign wpar = (^wdata_i) ^ parity_inj_i;
`else
  logic unused_parity_inj;
  assign unused_parity_inj = parity_inj_i;
`endif

  assign idle  = (state_q == IDLE);
  // A clear request in the same cycle wins over the write.
  assign wr_ok = we_i & idle & ~clear_i & ({1'b0, waddr_i} < NumWordsA)
               & ~((ZeroReg != 0) & (waddr_i == '0));

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    mem_d   = mem_q;
`ifdef IBEX_L2_RF_PARITY_EN
    par_d   = par_q;
`endif
    case (state_q)
      IDLE: begin
        if (clear_i) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        mem_d[cnt_q] = '0;
`ifdef IBEX_L2_RF_PARITY_EN
        par_d[cnt_q] = 1'b0;
`endif
        if (cnt_q == LastIdx) begin
          state_d = IDLE;
        end else begin
          cnt_d = cnt_q + AddrWidth'(1);
        end
      end
      default: state_d = IDLE;
    endcase
    if (wr_ok) begin
      mem_d[waddr_i] = wdata_i;
`ifdef IBEX_L2_RF_PARITY_EN
      par_d[waddr_i] = wpar;
`endif
    end
  end

  for (genvar p = 0; p < NumReadPorts; p++) begin : g_rd
    logic [AddrWidth-1:0] ra;
    logic                 in_rng;
    logic                 zero_hit;
    logic                 rd_acc;
    logic [DataWidth-1:0] word;
    logic                 par;

    assign ra       = raddr_i[p*AddrWidth +: AddrWidth];
    assign in_rng   = ({1'b0, ra} < NumWordsA);
    assign zero_hit = (ZeroReg != 0) & (ra == '0);
    assign rd_acc   = re_i[p] & idle;

    // wr_ok already implies a valid, non-zero address, so a match is a true bypass.
    always_comb begin
      word = '0;
      par  = 1'b0;
      if (wr_ok && (waddr_i == ra)) begin
        word = wdata_i;
`ifdef IBEX_L2_RF_PARITY_EN
        par  = wpar;
`endif
      end else if (in_rng && !zero_hit) begin
        word = mem_q[ra];
`ifdef IBEX_L2_RF_PARITY_EN
        par  = par_q[ra];
`endif
      end
    end

    assign rdata_d[p*DataWidth +: DataWidth] = rd_acc ? word : rdata_q[p*DataWidth +: DataWidth];
    assign rvalid_d[p]                       = rd_acc;
`ifdef IBEX_L2_RF_PARITY_EN
    assign perr_d[p] = rd_acc & ((^word) ^ par);
`else
    logic unused_par;
    assign unused_par = par;
`endif
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      rdata_q  <= '0;
      rvalid_q <= '0;
      for (int i = 0; i < NumWords; i++) begin
        mem_q[i] <= '0;
`ifdef IBEX_L2_RF_PARITY_EN
        par_q[i] <= 1'b0;
`endif
      end
`ifdef IBEX_L2_RF_PARITY_EN
      perr_q   <= '0;
`endif
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      rdata_q  <= rdata_d;
      rvalid_q <= rvalid_d;
      mem_q    <= mem_d;
`ifdef IBEX_L2_RF_PARITY_EN
      par_q    <= par_d;
      perr_q   <= perr_d;
`endif
    end
  end

  assign rdata_o  = rdata_q;
  assign rvalid_o = rvalid_q;
  assign busy_o   = (state_q == CLEAR);
`ifdef IBEX_L2_RF_PARITY_EN
  assign parity_err_o = perr_q;
`else
  assign parity_err_o = '0;
`endif

endmodule

// File: tb/tb_ibex_l2_register_file_mp.sv
// Scoreboard bench for ibex_l2_register_file_mp with default parameters (32x28, 2 read ports, ZeroReg=1).
module tb_ibex_l2_register_file_mp;
  localparam int DW = 32;
  localparam int NW = 28;
  localparam int NP = 2;
  localparam int AW = 5;
`ifdef IBEX_L2_RF_PARITY_EN
  localparam logic PEN = 1'b1;
`else
  localparam logic PEN = 1'b0;
`endif

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             we;
  logic [AW-1:0]    waddr;
  logic [DW-1:0]    wdata;
  logic [NP-1:0]    re;
  logic [NP*AW-1:0] raddr;
  logic [NP*DW-1:0] rdata;
  logic [NP-1:0]    rvalid;
  logic             clear;
  logic             busy;
  logic             inj;
  logic [NP-1:0]    perr;

  int checks = 0;
  int fails  = 0;
  logic [DW:0] q0 [$];
  logic [DW:0] q1 [$];
  logic [DW:0] mon_exp;

  ibex_l2_register_file_mp dut (
    .clk_i(clk), .rst_ni(rst_n), .we_i(we), .waddr_i(waddr), .wdata_i(wdata),
    .re_i(re), .raddr_i(raddr), .rdata_o(rdata), .rvalid_o(rvalid),
    .clear_i(clear), .busy_o(busy), .parity_inj_i(inj), .parity_err_o(perr)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // Monitor: every valid beat must match the oldest expectation queued for that port.
  always @(negedge clk) begin
    if (rst_n) begin
      for (int p = 0; p < NP; p++) begin
        if (rvalid[p]) begin
          if ((p == 0 && q0.size() == 0) || (p == 1 && q1.size() == 0)) begin
            checks++;
            fails++;
            $display("FAIL unexpected_rvalid port%0d: got data %h, no request pending", p, rdata[p*DW +: DW]);
          end else begin
            if (p == 0) mon_exp = q0.pop_front();
            else        mon_exp = q1.pop_front();
            chk($sformatf("rdata_p%0d", p), rdata[p*DW +: DW], mon_exp[DW-1:0]);
            chk($sformatf("perr_p%0d", p), 32'(perr[p]), 32'(mon_exp[DW]));
          end
        end
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic wr(input logic [AW-1:0] a, input logic [DW-1:0] d, input logic in_j = 1'b0);
    we = 1'b1; waddr = a; wdata = d; inj = in_j;
    tick();
    we = 1'b0; inj = 1'b0;
  endtask

  task automatic rd(input logic [1:0] m, input logic [AW-1:0] a0, input logic [AW-1:0] a1,
                    input logic [DW-1:0] e0, input logic [DW-1:0] e1,
                    input logic p0 = 1'b0, input logic p1 = 1'b0);
    re = m; raddr = {a1, a0};
    if (m[0]) q0.push_back({p0, e0});
    if (m[1]) q1.push_back({p1, e1});
    tick();
    re = '0;
  endtask

  task automatic count_busy(input string name);
    int n;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      n++;
      tick();
    end
    chk(name, n, NW);
  endtask

  initial begin
    int n;
    we = 0; waddr = '0; wdata = '0; re = '0; raddr = '0; clear = 0; inj = 0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_rvalid", 32'(rvalid), 0);
    chk("reset_busy", 32'(busy), 0);
    chk("reset_rdata0", rdata[31:0], 0);
    chk("reset_perr", 32'(perr), 0);
    rst_n = 1'b1;
    tick();

    // Basic write then read on port 0 only.
    wr(5, 32'hDEADBEEF);
    rd(2'b01, 5, 0, 32'hDEADBEEF, 0);
    chk("single_port_rvalid", 32'(rvalid), 32'h1);
    tick();
    chk("idle_rvalid", 32'(rvalid), 0);
    chk("rdata_hold", rdata[31:0], 32'hDEADBEEF);

    // Hard-wired zero word, out-of-range address, top valid word.
    wr(0, 32'h1234);
    rd(2'b01, 0, 0, 32'h0, 0);
    wr(28, 32'h55AA55AA);
    rd(2'b11, 28, 31, 32'h0, 32'h0);
    wr(27, 32'hCAFEF00D);
    rd(2'b10, 0, 27, 0, 32'hCAFEF00D);

    // Write-first bypass on both ports, then the stored value.
    we = 1; waddr = 3; wdata = 32'hA5A5A5A5;
    rd(2'b11, 3, 3, 32'hA5A5A5A5, 32'hA5A5A5A5);
    we = 0;
    rd(2'b11, 3, 5, 32'hA5A5A5A5, 32'hDEADBEEF);

    // Fill, clear with a same-cycle read returning pre-clear data.
    for (int i = 1; i < NW; i++) wr(AW'(i), 32'(i));
    clear = 1;
    rd(2'b11, 5, 27, 32'd5, 32'd27);
    clear = 0;
    n = 0;
    while (busy === 1'b1 && n < 100) begin
      we = (n == 10); waddr = 1; wdata = 32'hBAD0BAD0;
      re = (n == 5) ? 2'b11 : 2'b00; raddr = {5'd2, 5'd2};
      n++;
      tick();
    end
    we = 0; re = '0;
    chk("busy_cycles", n, NW);
    for (int i = 0; i < NW; i++) rd(2'b11, AW'(i), AW'(NW - 1 - i), 0, 0);

    // Reset in the middle of a clear.
    for (int i = 1; i < NW; i++) wr(AW'(i), 32'(i + 100));
    clear = 1;
    tick();
    clear = 0;
    repeat (10) tick();
    chk("busy_before_reset", 32'(busy), 1);
    #2 rst_n = 1'b0;
    #1;
    chk("busy_async_reset", 32'(busy), 0);
    chk("rvalid_async_reset", 32'(rvalid), 0);
    chk("rdata_async_reset", rdata[63:32], 0);
    @(negedge clk);
    rst_n = 1'b1;
    tick();
    rd(2'b11, 20, 27, 0, 0);
    rd(2'b01, 5, 0, 0, 0);
    clear = 1;
    tick();
    clear = 0;
    count_busy("busy_cycles_after_reset");

    // Parity: injection, clean rewrite, bypassed injected write.
    wr(7, 32'h1, 1'b1);
    rd(2'b01, 7, 0, 32'h1, 0, PEN, 1'b0);
    wr(7, 32'h1, 1'b0);
    rd(2'b01, 7, 0, 32'h1, 0, 1'b0, 1'b0);
    we = 1; waddr = 9; wdata = 32'h3; inj = 1;
    rd(2'b10, 0, 9, 0, 32'h3, 1'b0, PEN);
    we = 0; inj = 0;
    rd(2'b11, 9, 0, 32'h3, 0, PEN, 1'b0);

    repeat (3) tick();
    chk("q0_drained", q0.size(), 0);
    chk("q1_drained", q1.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, fails);
    $finish;
  end
endmodule
